// File: rtl/uart_line_reader.sv
// uart_line_reader: drains the UART RX FIFO and assembles CR-terminated ASCII
// lines into a local buffer, handing each completed line downstream through a
// valid/ack handshake with registered random-access byte reads.
//
// Ports:
//   clk, reset       system clock, asynchronous active-high reset
//   rx_empty, r_data UART RX FIFO status and head byte
//   rd_uart          FIFO pop strobe (combinational)
//   line_valid       a completed line is held in the buffer
//   line_len         byte count of the held line (terminator excluded)
//   rd_addr, rd_byte buffer read port, one-cycle latency
//   line_ack         downstream releases the held line
//   prompt_tick      one-cycle pulse per prompt byte popped
//   e_ovf, clr_err   sticky overflow flag and its clear
module uart_line_reader #(
  parameter int unsigned ADDR_W = 5,
  parameter logic [7:0]  TERM   = 8'h0D,
  parameter logic [7:0]  SKIP   = 8'h0A,
  parameter logic [7:0]  PROMPT = 8'h3E
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_empty,
  input  logic [7:0]        r_data,
  output logic              rd_uart,
  output logic              line_valid,
  output logic [ADDR_W:0]   line_len,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_byte,
  input  logic              line_ack,
  output logic              prompt_tick,
  output logic              e_ovf,
  input  logic              clr_err
);

  localparam int unsigned    DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [ADDR_W:0] count_q, count_d;
  logic [ADDR_W:0] line_len_q, line_len_d;
  logic            line_valid_q, line_valid_d;
  logic            prompt_tick_q, prompt_tick_d;
  logic            e_ovf_q, e_ovf_d;
  logic [7:0]      rd_byte_q;
  logic            pop;
  logic            wr_en;
  logic            close_line;

  logic [7:0] mem [DEPTH];

  // Next-state and byte classification; SKIP is checked first so it can never
  // be mistaken for a terminator or stored.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    line_len_d    = line_len_q;
    line_valid_d  = line_valid_q;
    prompt_tick_d = 1'b0;
    e_ovf_d       = e_ovf_q & ~clr_err;
    pop           = 1'b0;
    wr_en         = 1'b0;
    close_line    = 1'b0;

    unique case (state_q)
      COLLECT: begin
        pop = ~rx_empty;
        if (pop) begin
          if (r_data == SKIP) begin
            close_line = 1'b0;
          end else if (r_data == TERM) begin
            close_line = (count_q != '0);
          end else if (r_data == PROMPT) begin
            prompt_tick_d = 1'b1;
            close_line    = (count_q != '0);
          end else if (count_q != FULL) begin
            wr_en   = 1'b1;
            count_d = count_q + (ADDR_W+1)'(1);
          end else begin
            // Buffer full: drop the byte but keep the line open.
            e_ovf_d = 1'b1;
          end
        end
        if (close_line) begin
          line_len_d   = count_q;
          line_valid_d = 1'b1;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (line_ack) begin
          line_valid_d = 1'b0;
          count_d      = '0;
          state_d      = COLLECT;
        end
      end
    endcase
  end

  // Control and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= COLLECT;
      count_q       <= '0;
      line_len_q    <= '0;
      line_valid_q  <= 1'b0;
      prompt_tick_q <= 1'b0;
      e_ovf_q       <= 1'b0;
      rd_byte_q     <= 8'h00;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      line_len_q    <= line_len_d;
      line_valid_q  <= line_valid_d;
      prompt_tick_q <= prompt_tick_d;
      e_ovf_q       <= e_ovf_d;
      rd_byte_q     <= mem[rd_addr];
    end
  end

  // Line buffer storage; intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[count_q[ADDR_W-1:0]] <= r_data;
    end
  end

  assign rd_uart     = pop;
  assign line_valid  = line_valid_q;
  assign line_len    = line_len_q;
  assign rd_byte     = rd_byte_q;
  assign prompt_tick = prompt_tick_q;
  assign e_ovf       = e_ovf_q;

endmodule

// File: tb/tb_uart_line_reader.sv
// Testbench for uart_line_reader: a queue-based UART FIFO feeds byte streams,
// and a line-level reference model predicts lines, prompts and overflow.
module tb_uart_line_reader;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 32;
  localparam logic [7:0]  TERM   = 8'h0D;
  localparam logic [7:0]  SKIP   = 8'h0A;
  localparam logic [7:0]  PROMPT = 8'h3E;

  logic              clk;
  logic              reset;
  logic              rx_empty;
  logic [7:0]        r_data;
  logic              rd_uart;
  logic              line_valid;
  logic [ADDR_W:0]   line_len;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_byte;
  logic              line_ack;
  logic              prompt_tick;
  logic              e_ovf;
  logic              clr_err;

  int checks;
  int errors;

  uart_line_reader #(
    .ADDR_W(ADDR_W), .TERM(TERM), .SKIP(SKIP), .PROMPT(PROMPT)
  ) dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data),
    .rd_uart(rd_uart), .line_valid(line_valid), .line_len(line_len),
    .rd_addr(rd_addr), .rd_byte(rd_byte), .line_ack(line_ack),
    .prompt_tick(prompt_tick), .e_ovf(e_ovf), .clr_err(clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: pops follow rd_uart as seen just before the edge.
  logic [7:0] fifo[$];
  int  pop_cnt;
  bit  pop_now;

  task automatic refresh_fifo();
    rx_empty = (fifo.size() == 0);
    r_data   = (fifo.size() > 0) ? fifo[0] : 8'h00;
  endtask

  always @(posedge clk) begin
    pop_now = rd_uart && !reset;
    #1;
    if (pop_now && fifo.size() > 0) begin
      void'(fifo.pop_front());
      pop_cnt++;
    end
    refresh_fifo();
  end

  // Event monitors.
  int prompt_cnt;
  int rise_cnt;
  bit prev_valid;
  always @(negedge clk) begin
    if (prompt_tick === 1'b1) prompt_cnt++;
    if (line_valid === 1'b1 && !prev_valid) rise_cnt++;
    prev_valid = (line_valid === 1'b1);
  end

  // Reference model: line-level view of the byte stream.
  logic [7:0] mdl_cur[$];
  bit         mdl_ovf;
  int         exp_len[$];
  logic [7:0] exp_data[$];
  bit         exp_byprompt[$];
  bit         exp_ovf_at[$];
  int         exp_prompts;
  logic [7:0] stim[$];
  int         last_gap;

  task automatic model_close(input bit by_prompt);
    exp_len.push_back(mdl_cur.size());
    foreach (mdl_cur[i]) exp_data.push_back(mdl_cur[i]);
    exp_byprompt.push_back(by_prompt);
    exp_ovf_at.push_back(mdl_ovf);
    mdl_cur.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == SKIP) begin
    end else if (b == TERM) begin
      if (mdl_cur.size() > 0) model_close(1'b0);
    end else if (b == PROMPT) begin
      exp_prompts++;
      if (mdl_cur.size() > 0) model_close(1'b1);
    end else if (mdl_cur.size() < DEPTH) begin
      mdl_cur.push_back(b);
    end else begin
      mdl_ovf = 1'b1;
    end
  endtask

  function automatic logic [7:0] rand_data();
    logic [7:0] d;
    d = 8'($urandom_range(0, 255));
    if (d == SKIP || d == TERM || d == PROMPT) d = d ^ 8'h80;
    return d;
  endfunction

  // Feed stim through the FIFO and check every predicted line and event.
  task automatic run_stream(input string name, input int hold_cycles);
    int data_idx;
    int wait_n;
    int fsz;
    exp_len.delete(); exp_data.delete(); exp_byprompt.delete(); exp_ovf_at.delete();
    exp_prompts = 0;
    foreach (stim[i]) model_byte(stim[i]);
    @(negedge clk);
    prompt_cnt = 0; rise_cnt = 0; pop_cnt = 0;
    foreach (stim[i]) fifo.push_back(stim[i]);
    refresh_fifo();
    data_idx = 0;
    for (int l = 0; l < exp_len.size(); l++) begin
      wait_n = 0;
      while (line_valid !== 1'b1 && wait_n < 400) begin
        @(negedge clk);
        wait_n++;
      end
      last_gap = wait_n;
      checks++;
      if (line_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s line%0d timeout: line_valid=%b expected 1", name, l, line_valid);
        return;
      end
      checks++;
      if (int'(line_len) != exp_len[l]) begin
        errors++;
        $display("FAIL %s line%0d line_len: got %0d expected %0d", name, l, line_len, exp_len[l]);
      end
      checks++;
      if (prompt_tick !== exp_byprompt[l]) begin
        errors++;
        $display("FAIL %s line%0d prompt_tick at close: got %b expected %b", name, l, prompt_tick, exp_byprompt[l]);
      end
      checks++;
      if (e_ovf !== exp_ovf_at[l]) begin
        errors++;
        $display("FAIL %s line%0d e_ovf: got %b expected %b", name, l, e_ovf, exp_ovf_at[l]);
      end
      fsz = fifo.size();
      for (int i = 0; i < hold_cycles; i++) begin
        checks++;
        if (rd_uart !== 1'b0 || fifo.size() != fsz) begin
          errors++;
          $display("FAIL %s line%0d hold: rd_uart=%b fifo=%0d expected 0/%0d", name, l, rd_uart, fifo.size(), fsz);
        end
        @(negedge clk);
      end
      for (int i = 0; i < exp_len[l]; i++) begin
        rd_addr = ADDR_W'(i);
        @(negedge clk);
        checks++;
        if (rd_byte !== exp_data[data_idx + i]) begin
          errors++;
          $display("FAIL %s line%0d byte%0d: got %h expected %h", name, l, i, rd_byte, exp_data[data_idx + i]);
        end
      end
      data_idx += exp_len[l];
      line_ack = 1'b1;
      @(negedge clk);
      line_ack = 1'b0;
      checks++;
      if (line_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s line%0d ack: line_valid=%b expected 0", name, l, line_valid);
      end
    end
    wait_n = 0;
    while (fifo.size() > 0 && wait_n < 400) begin
      @(negedge clk);
      wait_n++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (pop_cnt != stim.size()) begin
      errors++;
      $display("FAIL %s pops: got %0d expected %0d", name, pop_cnt, stim.size());
    end
    checks++;
    if (line_valid !== 1'b0 || rise_cnt != exp_len.size()) begin
      errors++;
      $display("FAIL %s lines: valid=%b rises=%0d expected 0/%0d", name, line_valid, rise_cnt, exp_len.size());
    end
    checks++;
    if (prompt_cnt != exp_prompts) begin
      errors++;
      $display("FAIL %s prompts: got %0d expected %0d", name, prompt_cnt, exp_prompts);
    end
    checks++;
    if (e_ovf !== mdl_ovf) begin
      errors++;
      $display("FAIL %s e_ovf end: got %b expected %b", name, e_ovf, mdl_ovf);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (line_valid !== 1'b0 || line_len !== '0 || prompt_tick !== 1'b0 ||
        e_ovf !== 1'b0 || rd_byte !== 8'h00) begin
      errors++;
      $display("FAIL %s: valid=%b len=%0d tick=%b ovf=%b byte=%h expected all 0",
               name, line_valid, line_len, prompt_tick, e_ovf, rd_byte);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    check_reset_outputs("reset_values");
    checks++;
    if (rd_uart !== 1'b0) begin
      errors++;
      $display("FAIL reset_rd_uart: got %b expected 0", rd_uart);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_at();
    stim = '{8'h41, 8'h54, 8'h0D};
    run_stream("at", 2);
  endtask

  task automatic test_blank();
    stim = '{8'h0D, 8'h0A, 8'h0D};
    run_stream("blank", 1);
  endtask

  task automatic test_ok_prompt();
    stim = '{8'h4F, 8'h4B, 8'h0D, 8'h0A, 8'h3E};
    run_stream("ok_prompt", 1);
    stim = '{8'h34, 8'h31, 8'h20, 8'h30, 8'h43, 8'h3E};
    run_stream("prompt_close", 1);
  endtask

  task automatic test_overflow();
    logic [7:0] x;
    stim.delete();
    for (int i = 0; i < 40; i++) stim.push_back(rand_data());
    stim.push_back(TERM);
    run_stream("ovf40", 2);
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    mdl_ovf = 1'b0;
    checks++;
    if (e_ovf !== 1'b0) begin
      errors++;
      $display("FAIL clr_err: e_ovf=%b expected 0", e_ovf);
    end
    stim.delete();
    for (int i = 0; i < 32; i++) stim.push_back(rand_data());
    run_stream("fill32", 1);
    // Drop and clear land in the same cycle: set must win.
    x = rand_data();
    fifo.push_back(x);
    refresh_fifo();
    clr_err = 1'b1;
    model_byte(x);
    @(negedge clk);
    clr_err = 1'b0;
    checks++;
    if (e_ovf !== 1'b1 || fifo.size() != 0) begin
      errors++;
      $display("FAIL clr_vs_drop: e_ovf=%b fifo=%0d expected 1/0", e_ovf, fifo.size());
    end
    stim = '{TERM};
    run_stream("fill_close", 1);
  endtask

  task automatic test_back_to_back();
    stim = '{8'h41, 8'h0D, 8'h42, 8'h0D};
    run_stream("b2b", 20);
    checks++;
    if (last_gap != 2) begin
      errors++;
      $display("FAIL b2b_gap: got %0d expected 2", last_gap);
    end
  endtask

  task automatic test_reset_midline();
    int wait_n;
    fifo.push_back(8'h41);
    fifo.push_back(8'h42);
    refresh_fifo();
    wait_n = 0;
    while (fifo.size() > 0 && wait_n < 100) begin
      @(negedge clk);
      wait_n++;
    end
    checks++;
    if (fifo.size() != 0) begin
      errors++;
      $display("FAIL midline_drain: fifo=%0d expected 0", fifo.size());
    end
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    mdl_cur.delete();
    mdl_ovf = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    stim = '{8'h43, 8'h0D};
    run_stream("after_reset", 1);
  endtask

  task automatic test_random();
    int len;
    int r;
    for (int it = 0; it < 10; it++) begin
      stim.delete();
      len = $urandom_range(1, 45);
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 9);
        if (r == 0) stim.push_back(SKIP);
        else if (r == 1) stim.push_back(TERM);
        else if (r == 2) stim.push_back(PROMPT);
        else stim.push_back(rand_data());
      end
      stim.push_back(TERM);
      run_stream($sformatf("rand%0d", it), $urandom_range(1, 5));
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rx_empty = 1'b1; r_data = 8'h00; rd_addr = '0;
    line_ack = 1'b0; clr_err = 1'b0;
    pop_cnt = 0; prompt_cnt = 0; rise_cnt = 0; prev_valid = 1'b0;
    mdl_ovf = 1'b0; last_gap = 0;
    test_reset();
    test_at();
    test_blank();
    test_ok_prompt();
    test_overflow();
    test_back_to_back();
    test_reset_midline();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_line_reader.md
# uart_line_reader

Consumer-side client of the UART receive FIFO: pops bytes whenever the FIFO is non-empty and assembles CR-terminated ASCII response lines into an internal line buffer. Each completed line is handed to downstream logic (the ELM response parser) through a valid/ack handshake with random-access byte reads. The block also flags the adapter prompt character and buffer overflow. It sits between the `uart` block's `rd_uart`/`r_data`/`rx_empty` port and the protocol logic.

## Interface
- `ADDR_W`, 5: line buffer address bits; capacity 2^ADDR_W bytes
- `TERM`, 8'h0D: line terminator (CR)
- `SKIP`, 8'h0A: byte discarded unconditionally (LF)
- `PROMPT`, 8'h3E: prompt character ('>')

- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `rx_empty`  in  1  UART RX FIFO empty
- `r_data`  in  8  UART RX FIFO head byte; valid whenever `rx_empty`=0
- `rd_uart`  out  1  pop strobe to UART RX FIFO (combinational)
- `line_valid`  out  1  completed line held in buffer
- `line_len`  out  ADDR_W+1  byte count of held line (excluding terminator)
- `rd_addr`  in  ADDR_W  line buffer read address
- `rd_byte`  out  8  buffer byte at `rd_addr`, registered
- `line_ack`  in  1  downstream releases the held line
- `prompt_tick`  out  1  one-cycle pulse per PROMPT byte received
- `e_ovf`  out  1  sticky: a byte was dropped because the buffer was full
- `clr_err`  in  1  clears `e_ovf`

## Operation
- Two states: COLLECT, HOLD. Reset → COLLECT.
- Reset values: `line_valid`=0, `line_len`=0, `prompt_tick`=0, `e_ovf`=0, `rd_byte`=0, internal count=0. Buffer RAM is not reset.
- `rd_uart` = (state==COLLECT) && !`rx_empty`. Each cycle with `rd_uart`=1 consumes exactly the `r_data` byte present in that cycle.
- Byte handling in COLLECT (first matching rule applies):
  - SKIP: discarded.
  - TERM: if count==0, discarded (blank lines never produce a line). Otherwise `line_len`←count, `line_valid`←1, state→HOLD.
  - PROMPT: `prompt_tick` pulses. If count>0, the line is closed exactly as for TERM; PROMPT is not stored.
  - Other byte, count<2^ADDR_W: mem[count]←byte, count←count+1.
  - Other byte, count==2^ADDR_W: byte dropped, `e_ovf`←1. Line remains open; the next TERM/PROMPT closes it with `line_len`=2^ADDR_W.
- HOLD: no pops; bytes accumulate in the UART FIFO. `line_ack`=1 → `line_valid`←0, count←0, state→COLLECT. `line_ack` outside HOLD is ignored.
- `rd_byte` ← mem[`rd_addr`] every cycle, in any state. Contents at addresses ≥`line_len` are don't-care.
- `e_ovf`: cleared by `clr_err`; set takes priority when both occur in the same cycle.
- Reset mid-line discards the partial line. Buffer contents are undefined after reset.

## Timing
- Throughput: 1 byte/clk in COLLECT.
- TERM popped in cycle N → `line_valid`=1 and `line_len` valid from N+1; `rd_uart`=0 from N+1.
- PROMPT popped in cycle N → `prompt_tick`=1 in cycle N+1 only.
- `line_ack` in cycle M → `line_valid`=0 in M+1; `rd_uart` may assert in M+1.
- `rd_addr` applied in cycle K → `rd_byte` valid in K+1.
- Byte stored in cycle N is readable via `rd_addr` from N+1.
- Overflow drop in cycle N → `e_ovf`=1 from N+1.

## Test plan
- FIFO supplies "AT\r" (0x41,0x54,0x0D) → exactly 3 `rd_uart` cycles; `line_valid`=1 with `line_len`=2; rd_addr 0/1 → 0x41/0x54.
- "\r\n\r" only → 3 pops, `line_valid` stays 0, no `prompt_tick`.
- "OK\r\n>" → line with `line_len`=2 ("OK"); after ack, LF is popped, then `prompt_tick` pulses once and no second line is produced. Separately, "41 0C>" → line "41 0C" (`line_len`=5) and `prompt_tick` in the same cycle.
- ADDR_W=5, 40 non-special bytes then CR → `line_len`=32 containing the first 32 bytes, `e_ovf`=1. Then `clr_err` → `e_ovf`=0; `clr_err` coinciding with a drop → `e_ovf` stays 1.
- "A\rB\r" queued in FIFO, `line_ack` held off 20 cycles → `rd_uart`=0 throughout HOLD and "B" stays in the FIFO; ack → `line_valid` low for exactly one cycle pair, then a second line "B" is produced.
- `reset` asserted asynchronously after "AB" popped → outputs return to reset values immediately; subsequent "C\r" → `line_len`=1, byte 0x43.
